// File: rtl/risc5_pkg.sv
// risc5_pkg: shared core constants (PC width, reset vector, sequential PC increment).
package risc5_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;
  localparam int PC_INCR = 4;
endpackage

// File: rtl/pc_incr.sv
// pc_incr: constant +4 adder giving the sequential next PC, wrapping modulo 2^W.
module pc_incr
  import risc5_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [W-1:0] pc,
  output logic [W-1:0] pc_plus4
);
  assign pc_plus4 = pc + W'(PC_INCR);
endmodule

// File: rtl/pc_reg.sv
// pc_reg: program-counter register with load enable and async active-low reset.
// Define PC_ALIGN_CHECK_EN to add a registered 4-byte misalignment flag on pc_misal.
module pc_reg #(
  parameter int              XLEN         = risc5_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = risc5_pkg::RESET_VECTOR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [XLEN-1:0] pc_prev,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            pc_misal
);
  logic [XLEN-1:0] pc_d, pc_q;
  always_comb begin
    pc_d = pc_q;
    if (en) pc_d = pc_prev;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc_q <= RESET_VECTOR;
    else        pc_q <= pc_d;
  assign pc = pc_q;
  pc_incr #(.W(XLEN)) u_incr (.pc(pc_q), .pc_plus4(pc_plus4));
`ifdef PC_ALIGN_CHECK_EN
  logic misal_d, misal_q;
  always_comb begin
    misal_d = misal_q;
    if (en) misal_d = pc_prev[1:0] != 2'b00;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) misal_q <= 1'b0;
    else        misal_q <= misal_d;
  assign pc_misal = misal_q;
`else
  assign pc_misal = 1'b0;
`endif
endmodule

// File: tb/tb_pc_reg.sv
// tb_pc_reg: directed self-checking bench for pc_reg (reset, load, stall, wrap, misalign, glitch).
module tb_pc_reg;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [31:0] pc_prev;
  logic [31:0] pc, pc_plus4;
  logic        pc_misal;
  int n_checks = 0;
  int n_fail = 0;
`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN_ON = 1'b1;
`else
  localparam bit ALIGN_ON = 1'b0;
`endif

  pc_reg dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pc_prev(pc_prev),
    .pc(pc), .pc_plus4(pc_plus4), .pc_misal(pc_misal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] v);
    en = 1'b1;
    pc_prev = v;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; pc_prev = 32'h0000_1234;
    #1;
    check("rst_pc_t0", pc, 32'h0);
    check("rst_p4_t0", pc_plus4, 32'h4);
    check("rst_misal_t0", {31'd0, pc_misal}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_pc_hold", pc, 32'h0);
      check("rst_p4_hold", pc_plus4, 32'h4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    load(32'h0000_0010);
    check("load_pc", pc, 32'h10);
    check("load_p4", pc_plus4, 32'h14);
    en = 1'b0; pc_prev = 32'h0000_0020;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", pc, 32'h10);
    end
    load(32'h0000_0020);
    check("unstall_pc", pc, 32'h20);
    check("unstall_p4", pc_plus4, 32'h24);
    load(32'hFFFF_FFFC);
    check("wrap_pc", pc, 32'hFFFF_FFFC);
    check("wrap_p4", pc_plus4, 32'h0);
    check("wrap_misal", {31'd0, pc_misal}, 32'h0);
    load(32'h0000_0001);
    check("misal_pc", pc, 32'h1);
    check("misal_p4", pc_plus4, 32'h5);
    check("misal_set", {31'd0, pc_misal}, {31'd0, ALIGN_ON});
    en = 1'b0; pc_prev = 32'h0000_0008;
    tick();
    check("misal_held", {31'd0, pc_misal}, {31'd0, ALIGN_ON});
    check("misal_held_pc", pc, 32'h1);
    load(32'h0000_0008);
    check("misal_clr", {31'd0, pc_misal}, 32'h0);
    check("misal_clr_pc", pc, 32'h8);
    // en pulse lives strictly between edges, so no load may happen
    en = 1'b0;
    @(negedge clk);
    en = 1'b1; pc_prev = 32'h0000_0002;
    #2;
    en = 1'b0;
    tick();
    check("glitch_pc", pc, 32'h8);
    load(32'h0000_0003);
    check("pre_async_misal", {31'd0, pc_misal}, {31'd0, ALIGN_ON});
    #2;
    rst_n = 1'b0;
    #1;
    check("async_pc", pc, 32'h0);
    check("async_p4", pc_plus4, 32'h4);
    check("async_misal", {31'd0, pc_misal}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    load(32'h0000_0044);
    check("post_rst_pc", pc, 32'h44);
    check("post_rst_p4", pc_plus4, 32'h48);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
